// File: rtl/fetch_queue_stage_if.sv
// Instruction-memory request/response channel between the fetch stage (master)
// and the instruction memory (slave). Requests are valid/ready; responses return in order.
interface fetch_queue_stage_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();
  logic              imem_req_valid;
  logic              imem_req_ready;
  logic [ADDR_W-1:0] imem_req_addr;
  logic              imem_resp_valid;
  logic [DATA_W-1:0] imem_resp_data;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_resp_valid,
    input  imem_resp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_resp_valid,
    output imem_resp_data
  );
endinterface

// File: rtl/fetch_queue_stage.sv
// Decoupled instruction fetch: issues sequential addresses to a variable-latency memory
// and buffers returned instructions in a DEPTH-entry queue presented as {PC+4, instr}.
module fetch_queue_stage #(
  parameter int                 ADDR_W   = 32,
  parameter int                 DATA_W   = 32,
  parameter int                 DEPTH    = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         freeze,
  input  logic                         branchTaken,
  input  logic [ADDR_W-1:0]            branchAddress,
  fetch_queue_stage_if.master          mem,
  output logic                         out_valid,
  output logic [ADDR_W-1:0]            out_pc,
  output logic [DATA_W-1:0]            out_instr,
  output logic [$clog2(DEPTH+1)-1:0]   queue_count
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] resp_pc;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  outstanding;
  logic [CNT_W-1:0]  drop_cnt;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [ADDR_W-1:0] pc_mem    [DEPTH];
  logic [DATA_W-1:0] instr_mem [DEPTH];

  logic [CNT_W:0]    credit_used;
  logic              req_fire;
  logic              resp_take;
  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] resp_pc_next;

  // Credits cover both queued entries and in-flight requests, so a returning
  // response always has a free slot and the queue cannot overflow.
  assign credit_used        = {1'b0, count} + {1'b0, outstanding};
  assign mem.imem_req_valid = rst && !branchTaken && (credit_used < (CNT_W+1)'(DEPTH));
  assign mem.imem_req_addr  = fetch_pc;

  assign req_fire     = mem.imem_req_valid && mem.imem_req_ready;
  assign resp_take    = mem.imem_resp_valid && (outstanding != '0);
  assign push         = resp_take && !branchTaken && (drop_cnt == '0);
  assign pop          = out_valid && !freeze && !branchTaken;
  assign resp_pc_next = resp_pc + ADDR_W'(4);

  assign out_valid   = (count != '0);
  assign out_pc      = pc_mem[rd_ptr];
  assign out_instr   = instr_mem[rd_ptr];
  assign queue_count = count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      count       <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]    <= '0;
        instr_mem[i] <= '0;
      end
    end else begin
      outstanding <= outstanding + CNT_W'(req_fire) - CNT_W'(resp_take);
      if (branchTaken) begin
        // Everything still in flight belongs to the old path and must be discarded.
        fetch_pc <= branchAddress;
        resp_pc  <= branchAddress;
        drop_cnt <= outstanding - CNT_W'(resp_take);
        count    <= '0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
      end else begin
        if (req_fire) begin
          fetch_pc <= fetch_pc + ADDR_W'(4);
        end
        if (resp_take && (drop_cnt != '0)) begin
          drop_cnt <= drop_cnt - CNT_W'(1);
        end
        if (push) begin
          pc_mem[wr_ptr]    <= resp_pc_next;
          instr_mem[wr_ptr] <= mem.imem_resp_data;
          wr_ptr            <= wr_ptr + PTR_W'(1);
          resp_pc           <= resp_pc_next;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
        count <= count + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Scoreboard bench for fetch_queue_stage: a memory model answers requests, directed
// phases push the expected {pc, instr} stream and a monitor checks every popped entry.
module tb_fetch_queue_stage;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              freeze = 1'b0;
  logic              branchTaken = 1'b0;
  logic [ADDR_W-1:0] branchAddress = '0;
  logic              out_valid;
  logic [ADDR_W-1:0] out_pc;
  logic [DATA_W-1:0] out_instr;
  logic [2:0]        queue_count;

  fetch_queue_stage_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  fetch_queue_stage #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .RESET_PC(32'h0)
  ) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .branchTaken(branchTaken),
    .branchAddress(branchAddress), .mem(bus), .out_valid(out_valid),
    .out_pc(out_pc), .out_instr(out_instr), .queue_count(queue_count)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;
  typedef struct { logic [31:0] addr; int due; } req_t;

  exp_t sb[$];
  req_t pend[$];
  int   total = 0;
  int   passed = 0;
  int   pop_cnt = 0;
  int   lat = 1;
  bit   toggle = 1'b0;
  int   cyc = 0;

  function automatic logic [31:0] imem_word(logic [31:0] a);
    return a ^ 32'hDEAD_0013;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  // Expected entries for a sequential run starting at fetch address 'start'.
  task automatic expect_run(logic [31:0] start, int n);
    logic [31:0] a;
    exp_t        e;
    for (int i = 0; i < n; i++) begin
      a       = start + 32'(4 * i);
      e.pc    = a + 32'd4;
      e.instr = imem_word(a);
      sb.push_back(e);
    end
  endtask

  // Memory model: in-order responses 'lat' cycles after acceptance.
  initial begin
    req_t r;
    bus.imem_req_ready  = 1'b1;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = '0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (pend.size() != 0 && pend[0].due <= cyc) begin
        bus.imem_resp_valid = 1'b1;
        bus.imem_resp_data  = imem_word(pend[0].addr);
        pend.delete(0);
      end else begin
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = '0;
      end
      bus.imem_req_ready = toggle ? ~bus.imem_req_ready : 1'b1;
      @(negedge clk);
      if (rst && bus.imem_req_valid && bus.imem_req_ready) begin
        r.addr = bus.imem_req_addr;
        r.due  = cyc + lat;
        pend.push_back(r);
      end
    end
  end

  // Monitor: every entry leaving the queue is compared against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst && out_valid && !freeze && !branchTaken) begin
        pop_cnt++;
        if (sb.size() == 0) begin
          total++;
          $display("FAIL unexpected_pop: out_pc=0x%0h with nothing expected", out_pc);
        end else begin
          e = sb.pop_front();
          check("entry_pc", {32'h0, out_pc}, {32'h0, e.pc});
          check("entry_instr", {32'h0, out_instr}, {32'h0, e.instr});
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit, checks %0d/%0d", passed, total);
    $fatal(1, "watchdog expired");
  end

  task automatic flush_to(logic [31:0] target);
    @(posedge clk); #1;
    branchAddress = target;
    branchTaken   = 1'b1;
    sb.delete();
    expect_run(target, 200);
  endtask

  initial begin
    int maxq;
    int p0;
    int waited;
    bit saw_req;

    rst = 1'b1;
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_pc", 64'(out_pc), 64'd0);
    check("rst_out_instr", 64'(out_instr), 64'd0);
    check("rst_queue_count", 64'(queue_count), 64'd0);
    check("rst_req_valid", 64'(bus.imem_req_valid), 64'd0);

    // Latency 1, always ready, no freeze.
    @(posedge clk); #1;
    expect_run(32'h0, 200);
    pop_cnt = 0;
    rst = 1'b1;
    @(negedge clk);
    check("first_req_valid", 64'(bus.imem_req_valid), 64'd1);
    check("first_req_addr", 64'(bus.imem_req_addr), 64'h0);
    maxq = int'(queue_count);
    repeat (9) begin
      @(negedge clk);
      if (int'(queue_count) > maxq) maxq = int'(queue_count);
    end
    #1;
    check("l1_max_count_le2", 64'(maxq <= 2), 64'd1);
    check("l1_pops", 64'(pop_cnt), 64'd8);

    // Freeze: queue fills to DEPTH and requests stop; head holds.
    @(posedge clk); #1;
    freeze = 1'b1;
    repeat (10) @(negedge clk);
    check("freeze_count_full", 64'(queue_count), 64'd4);
    check("freeze_req_stopped", 64'(bus.imem_req_valid), 64'd0);
    check("freeze_out_valid", 64'(out_valid), 64'd1);
    check("freeze_head_pc", 64'(out_pc), 64'h24);
    check("freeze_head_instr", 64'(out_instr), 64'(imem_word(32'h20)));

    @(posedge clk); #1;
    freeze = 1'b0;
    p0 = pop_cnt;
    saw_req = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus.imem_req_valid) saw_req = 1'b1;
    end
    #1;
    check("unfreeze_pops", 64'(pop_cnt - p0), 64'd6);
    check("unfreeze_req_resumed", 64'(saw_req), 64'd1);

    // Latency 3 with ready toggling every cycle.
    @(posedge clk); #1;
    lat = 3;
    toggle = 1'b1;
    p0 = pop_cnt;
    repeat (30) @(negedge clk);
    #1;
    check("l3_progress", 64'(pop_cnt - p0 >= 5), 64'd1);

    // Flush with responses in flight and entries queued.
    @(posedge clk); #1;
    toggle = 1'b0;
    freeze = 1'b1;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (queue_count < 3'd2 && waited < 20);
    check("fill_before_flush", 64'(queue_count >= 3'd2), 64'd1);
    flush_to(32'h100);
    @(posedge clk); #1;
    branchTaken = 1'b0;
    freeze = 1'b0;
    @(negedge clk);
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_queue_count", 64'(queue_count), 64'd0);
    check("redirect_req_valid", 64'(bus.imem_req_valid), 64'd1);
    check("redirect_req_addr", 64'(bus.imem_req_addr), 64'h100);
    repeat (15) @(negedge clk);

    // Flush coinciding with a response and a pop in steady latency-1 flow.
    @(posedge clk); #1;
    lat = 1;
    repeat (10) @(negedge clk);
    flush_to(32'h200);
    @(posedge clk); #1;
    branchTaken = 1'b0;
    p0 = pop_cnt;
    @(negedge clk);
    check("flush2_queue_count", 64'(queue_count), 64'd0);
    check("flush2_req_addr", 64'(bus.imem_req_addr), 64'h200);
    repeat (9) @(negedge clk);
    #1;
    check("flush2_pops", 64'(pop_cnt - p0), 64'd8);

    // Redirect near the top of the address space: increments wrap to zero.
    flush_to(32'hFFFF_FFF8);
    @(posedge clk); #1;
    branchTaken = 1'b0;
    p0 = pop_cnt;
    @(negedge clk);
    check("wrap_req_addr", 64'(bus.imem_req_addr), 64'hFFFF_FFF8);
    repeat (9) @(negedge clk);
    #1;
    check("wrap_pops", 64'(pop_cnt - p0), 64'd8);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
